// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: serve, rally, point pause, game over.
// Optional LED status display enabled by macro MATCH_LED_EN.
module pong_match_ctrl #(
    parameter int         WIN_SCORE    = 7,
    parameter int         PAUSE_FRAMES = 60,
    parameter logic [3:0] SERVE_KEY    = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] keys_1,
    input  logic [3:0] keys_2,
    input  logic       frame_tick,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [2:0] state,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       ball_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [1:0] winner,
    output logic [7:0] led
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] L_WIN   = 4'(WIN_SCORE);
    localparam logic [7:0] L_PAUSE = 8'(PAUSE_FRAMES);

    state_t     r_state;
    logic [3:0] r_score_1;
    logic [3:0] r_score_2;
    logic [3:0] r_keys_1_q;
    logic [3:0] r_keys_2_q;
    logic       r_ball_en;
    logic       r_ball_reset;
    logic       r_serve_dir;
    logic [1:0] r_winner;
    logic [7:0] r_frame_cnt;

    logic       w_press_1;
    logic       w_press_2;
    logic       w_any_press;
    logic       w_serve_press;
    logic       w_game_won;
    logic [7:0] w_frame_next;

    // A press is the first cycle a player's keycode shows SERVE_KEY.
    assign w_press_1     = (keys_1 == SERVE_KEY) && (r_keys_1_q != SERVE_KEY);
    assign w_press_2     = (keys_2 == SERVE_KEY) && (r_keys_2_q != SERVE_KEY);
    assign w_any_press   = w_press_1 || w_press_2;
    assign w_serve_press = r_serve_dir ? w_press_1 : w_press_2;
    assign w_game_won    = (r_score_1 == L_WIN) || (r_score_2 == L_WIN);
    assign w_frame_next  = r_frame_cnt + 8'd1;

`ifdef MATCH_LED_EN
    logic [7:0] r_led;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_score_1    <= 4'd0;
            r_score_2    <= 4'd0;
            r_keys_1_q   <= 4'h0;
            r_keys_2_q   <= 4'h0;
            r_ball_en    <= 1'b0;
            r_ball_reset <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_winner     <= 2'd0;
            r_frame_cnt  <= 8'd0;
`ifdef MATCH_LED_EN
            r_led        <= 8'h00;
`endif
        end else begin
            r_keys_1_q   <= keys_1;
            r_keys_2_q   <= keys_2;
            r_ball_reset <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_score_1 <= 4'd0;
                    r_score_2 <= 4'd0;
                    r_winner  <= 2'd0;
                    r_ball_en <= 1'b0;
                    if (w_any_press) begin
                        r_state      <= S_SERVE;
                        r_serve_dir  <= w_press_1;
                        r_ball_reset <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (w_serve_press) begin
                        r_state   <= S_PLAY;
                        r_ball_en <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (miss_l || miss_r) begin
                        r_state     <= S_POINT;
                        r_ball_en   <= 1'b0;
                        r_frame_cnt <= 8'd0;
`ifdef MATCH_LED_EN
                        r_led       <= 8'h01;
`endif
                        // A simultaneous double miss is a dead ball: no score, same server.
                        if (miss_l && !miss_r) begin
                            if (r_score_2 != L_WIN) r_score_2 <= r_score_2 + 4'd1;
                            r_serve_dir <= 1'b0;
                        end else if (miss_r && !miss_l) begin
                            if (r_score_1 != L_WIN) r_score_1 <= r_score_1 + 4'd1;
                            r_serve_dir <= 1'b1;
                        end
                    end
                end
                S_POINT: begin
                    if (frame_tick) begin
                        r_frame_cnt <= w_frame_next;
`ifdef MATCH_LED_EN
                        r_led       <= {r_led[6:0], r_led[7]};
`endif
                        if (w_frame_next == L_PAUSE) begin
                            if (w_game_won) begin
                                r_state  <= S_OVER;
                                r_winner <= (r_score_1 == L_WIN) ? 2'd1 : 2'd2;
`ifdef MATCH_LED_EN
                                r_led    <= (r_score_1 == L_WIN) ? 8'h0F : 8'hF0;
`endif
                            end else begin
                                r_state      <= S_SERVE;
                                r_ball_reset <= 1'b1;
`ifdef MATCH_LED_EN
                                r_led        <= {r_score_1, r_score_2};
`endif
                            end
                        end
                    end
                end
                S_OVER: begin
                    r_ball_en <= 1'b0;
                    if (w_any_press) begin
                        r_state   <= S_IDLE;
                        r_score_1 <= 4'd0;
                        r_score_2 <= 4'd0;
                        r_winner  <= 2'd0;
`ifdef MATCH_LED_EN
                        r_led     <= 8'h00;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign score_1    = r_score_1;
    assign score_2    = r_score_2;
    assign ball_en    = r_ball_en;
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;
    assign winner     = r_winner;
`ifdef MATCH_LED_EN
    assign led        = r_led;
`else
    assign led        = 8'h00;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - Directed bench for pong_match_ctrl with an in-bench match model.
module tb_pong_match_ctrl;

    localparam int         WIN = 7;
    localparam int         PF  = 60;
    localparam logic [3:0] KEY = 4'hA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] keys_1, keys_2;
    logic       frame_tick, miss_l, miss_r;
    logic [2:0] state;
    logic [3:0] score_1, score_2;
    logic       ball_en, ball_reset, serve_dir;
    logic [1:0] winner;
    logic [7:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    pong_match_ctrl #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF), .SERVE_KEY(KEY)) dut (
        .clk(clk), .rst_n(rst_n), .keys_1(keys_1), .keys_2(keys_2),
        .frame_tick(frame_tick), .miss_l(miss_l), .miss_r(miss_r),
        .state(state), .score_1(score_1), .score_2(score_2),
        .ball_en(ball_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
        .winner(winner), .led(led)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Match model: mode 0 idle, 1 serve, 2 play, 3 point, 4 over.
    int m_mode, m_s1, m_s2, m_dir, m_br, m_cnt, m_h1, m_h2;
    bit mp1, mp2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_br = 0; m_cnt = 0; m_h1 = 0; m_h2 = 0;
        end else begin
            mp1  = (keys_1 == KEY) && (m_h1 != int'(KEY));
            mp2  = (keys_2 == KEY) && (m_h2 != int'(KEY));
            m_h1 = int'(keys_1);
            m_h2 = int'(keys_2);
            m_br = 0;
            if (m_mode == 0 && (mp1 || mp2)) begin
                m_dir = mp1 ? 1 : 0; m_mode = 1; m_br = 1;
            end else if (m_mode == 1 && ((m_dir == 1) ? mp1 : mp2)) begin
                m_mode = 2;
            end else if (m_mode == 2 && (miss_l || miss_r)) begin
                if (miss_l && !miss_r) begin m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; m_dir = 0; end
                if (miss_r && !miss_l) begin m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; m_dir = 1; end
                m_mode = 3; m_cnt = 0;
            end else if (m_mode == 3 && frame_tick) begin
                m_cnt++;
                if (m_cnt == PF) begin
                    if (m_s1 == WIN || m_s2 == WIN) m_mode = 4;
                    else begin m_mode = 1; m_br = 1; end
                end
            end else if (m_mode == 4 && (mp1 || mp2)) begin
                m_mode = 0; m_s1 = 0; m_s2 = 0;
            end
        end
    end

    function automatic int exp_winner();
        if (m_mode != 4) return 0;
        return (m_s1 == WIN) ? 1 : 2;
    endfunction

    function automatic int exp_led();
`ifdef MATCH_LED_EN
        if (m_mode == 3) return 1 << (m_cnt % 8);
        if (m_mode == 4) return (m_s1 == WIN) ? 8'h0F : 8'hF0;
        return m_s1 * 16 + m_s2;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        check("state",      int'(state),      m_mode);
        check("score_1",    int'(score_1),    m_s1);
        check("score_2",    int'(score_2),    m_s2);
        check("ball_en",    int'(ball_en),    (m_mode == 2) ? 1 : 0);
        check("ball_reset", int'(ball_reset), m_br);
        check("serve_dir",  int'(serve_dir),  m_dir);
        check("winner",     int'(winner),     exp_winner());
        check("led",        int'(led),        exp_led());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pause_frames(input int n);
        frame_tick = 1'b1;
        repeat (n) tick();
        frame_tick = 1'b0;
    endtask

    task automatic press(input int who);
        if (who == 1) keys_1 = KEY; else keys_2 = KEY;
        tick();
        keys_1 = 4'h0;
        keys_2 = 4'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; keys_1 = KEY; keys_2 = 4'h0;
        frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_led", int'(led), 0);

        // Key already held through reset counts once, then holding does nothing more.
        rst_n = 1'b1;
        tick();
        check("lit_serve_state", int'(state), 1);
        check("lit_serve_dir", int'(serve_dir), 1);
        check("lit_ball_reset_on", int'(ball_reset), 1);
        tick();
        check("lit_ball_reset_off", int'(ball_reset), 0);
        repeat (98) tick();
        check("lit_held_key_serve", int'(state), 1);
        keys_1 = 4'h0;
        tick();

        press(2);
        check("lit_p2_ignored", int'(state), 1);
        miss_r = 1'b1; frame_tick = 1'b1;
        tick();
        miss_r = 1'b0; frame_tick = 1'b0;
        check("lit_miss_in_serve", int'(score_1), 0);

        press(1);
        check("lit_play_state", int'(state), 2);
        check("lit_play_ball_en", int'(ball_en), 1);
        miss_r = 1'b1;
        tick();
        miss_r = 1'b0;
        check("lit_point_state", int'(state), 3);
        check("lit_point_s1", int'(score_1), 1);
        check("lit_point_dir", int'(serve_dir), 1);

        pause_frames(59);
        check("lit_pause_59", int'(state), 3);
        pause_frames(1);
        check("lit_pause_60", int'(state), 1);
        check("lit_reserve_ball_reset", int'(ball_reset), 1);

        press(1);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        miss_l = 1'b1; miss_r = 1'b1;
        tick();
        miss_l = 1'b0; miss_r = 1'b0;
        check("lit_double_state", int'(state), 3);
        check("lit_double_s1", int'(score_1), 1);
        check("lit_double_s2", int'(score_2), 0);
        check("lit_double_dir", int'(serve_dir), 1);
        pause_frames(PF);
        press(1);

        for (int i = 1; i <= WIN; i++) begin
            miss_l = 1'b1;
            tick();
            miss_l = 1'b0;
            check("lit_loop_s2", int'(score_2), i);
            check("lit_loop_dir", int'(serve_dir), 0);
            pause_frames(PF);
            if (i < WIN) begin
                check("lit_loop_serve", int'(state), 1);
                press(2);
            end
        end
        check("lit_over_state", int'(state), 4);
        check("lit_over_winner", int'(winner), 2);
        check("model_pin_s2", m_s2, 7);
`ifdef MATCH_LED_EN
        check("lit_over_led", int'(led), 8'hF0);
`else
        check("lit_over_led", int'(led), 0);
`endif
        miss_l = 1'b1;
        tick();
        miss_l = 1'b0;
        check("lit_over_miss_ignored", int'(score_2), 7);
        press(1);
        check("lit_idle_state", int'(state), 0);
        check("lit_idle_s2", int'(score_2), 0);
        check("lit_idle_winner", int'(winner), 0);

        // Reset asserted between clock edges while in POINT.
        press(2);
        check("lit_p2_serve_dir", int'(serve_dir), 0);
        press(2);
        miss_r = 1'b1;
        tick();
        miss_r = 1'b0;
        pause_frames(5);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_s1", int'(score_1), 0);
        check("async_dir", int'(serve_dir), 0);
        check("async_ball_en", int'(ball_en), 0);
        check("async_ball_reset", int'(ball_reset), 0);
        check("async_winner", int'(winner), 0);
        check("async_led", int'(led), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, meaning points to win (legal 1..15).
REQ-002 SHALL have parameter PAUSE_FRAMES, default 60, meaning frame ticks spent in POINT (legal 1..255).
REQ-003 SHALL have parameter SERVE_KEY, default 4'hA, meaning keypad keycode that serves or starts.
REQ-004 SHALL have ports: clk input 1 25 MHz system clock; rst_n input 1 async active-low reset.
REQ-005 SHALL have ports: keys_1 input 4 player-1 keycode; keys_2 input 4 player-2 keycode.
REQ-006 SHALL have ports: frame_tick input 1 one-cycle pulse per video frame; miss_l input 1 one-cycle pulse, ball passed left edge; miss_r input 1 one-cycle pulse, ball passed right edge.
REQ-007 SHALL have ports: state output 3 current state code; score_1 output 4; score_2 output 4; ball_en output 1 ball motion enable; ball_reset output 1 one-cycle centre-ball pulse; serve_dir output 1 (0 = toward player 1/left, 1 = toward player 2/right); winner output 2 (0 none, 1 P1, 2 P2); led output 8.

Function
REQ-010 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; other codes SHALL never be reached.
REQ-011 SHALL define press_n as one cycle where keys_n == SERVE_KEY and the registered previous keys_n != SERVE_KEY (per-player edge detect, updated every cycle).
REQ-012 IDLE: scores 0, winner 0, ball_en 0; press_1 or press_2 -> SERVE with serve_dir = 1 if press_1 else 0 (press_1 wins if simultaneous).
REQ-013 Entry into SERVE SHALL assert ball_reset for exactly one cycle, registered, in the first SERVE cycle.
REQ-014 SERVE: ball_en 0; only the serving player (serve_dir 1 -> P1, 0 -> P2) press moves to PLAY; other player's press ignored.
REQ-015 PLAY: ball_en 1; miss_l alone -> score_2 += 1, serve_dir <= 0; miss_r alone -> score_1 += 1, serve_dir <= 1; either -> POINT next cycle.
REQ-016 PLAY with miss_l and miss_r in the same cycle SHALL change no score, keep serve_dir, and go to POINT.
REQ-017 Scores SHALL saturate at WIN_SCORE, never wrap.
REQ-018 POINT: ball_en 0; 8-bit frame counter cleared on entry, incremented per frame_tick; when count reaches PAUSE_FRAMES -> OVER if either score == WIN_SCORE, else SERVE.
REQ-019 OVER: winner = 1 if score_1 == WIN_SCORE else 2; ball_en 0; press_1 or press_2 -> IDLE (scores and winner cleared on IDLE entry).
REQ-020 miss_l/miss_r outside PLAY and frame_tick outside POINT SHALL be ignored.
REQ-021 All outputs SHALL be registered; state change visible one cycle after the causing input edge.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, scores 0, winner 0, ball_en 0, ball_reset 0, serve_dir 0, led 0, frame counter 0, key history registers 4'h0, regardless of current state.
REQ-031 After rst_n deasserts, a key already held at SERVE_KEY SHALL count as a press on the first clk edge (history was 0).

Configuration
REQ-040 With macro MATCH_LED_EN defined, led SHALL show: POINT walking one (8'h01 on entry, rotate left per frame_tick); OVER 8'h0F (P1) or 8'hF0 (P2); other states {score_1, score_2}.
REQ-041 Without MATCH_LED_EN, led SHALL be constant 8'h00 and no LED logic synthesised.

Verification
REQ-050 Reset, keys_1 = SERVE_KEY one cycle -> SERVE, serve_dir 1, ball_reset one pulse; keys_2 press ignored; keys_1 release/press -> PLAY, ball_en 1.
REQ-051 PLAY, miss_r pulse -> score_1 = 1, serve_dir 1, POINT; 60 frame_ticks -> SERVE with new ball_reset pulse.
REQ-052 PLAY, miss_l and miss_r same cycle -> scores unchanged, POINT.
REQ-053 Seven miss_l points -> score_2 = 7, after pause OVER, winner 2, led 8'hF0 (MATCH_LED_EN); extra miss_l ignored; press -> IDLE, scores 0.
REQ-054 Keycode held at SERVE_KEY 100 cycles -> exactly one press registered.
REQ-055 rst_n pulsed low mid-POINT -> all outputs reset values asynchronously, state IDLE.
